mux_response_checker: RTL
=========================

# mux_response_checker

Synthesizable response checker for the three 2:1 mux implementations (`rtl`, `passgate`, `remodeled`). It is the receiving end of the mux stimulus flow: it watches the applied stimulus (`mux_sel`, `mux_in1`, `mux_in0`) and waits for a settle window after each stimulus change. It then compares all three mux outputs against the golden `sel ? in1 : in0` and accumulates pass/fail status, vector and error counts, and the first failing vector. It sits beside the mux block on the bench or in an on-chip self-test wrapper.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: number of stable clocks required after a stimulus change before a check (legal range 1..255).
- `CNT_W`, default 16: width of `vec_count` and `err_count`.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  checking active while high.
- `clear`  in  1  synchronous clear of results.
- `mux_in0`, `mux_in1`, `mux_sel`  in  1 each  applied stimulus; synchronous to `clk`.
- `mux_out_rtl`, `mux_out_passgate`, `mux_out_remodeled`  in  1 each  observed outputs.
- `check_strobe`  out  1  one-cycle pulse per completed check.
- `vec_count`  out  `CNT_W`  vectors checked; saturating.
- `err_count`  out  `CNT_W`  vectors with at least one mismatch; saturating.
- `fail`  out  1  sticky; set on the first mismatch.
- `pass`  out  1  high when `vec_count` != 0 and `fail` = 0.
- `first_fail_vec`  out  3  {sel,in1,in0} of the first failing vector.
- `first_fail_mask`  out  3  {remodeled,passgate,rtl} mismatch bits of the first failing vector.

## Operation
- All six mux signals are registered once (input stage). `stim` = registered {sel,in1,in0}; `prev` = `stim` delayed one clock. A change is `stim` != `prev`.
- Golden value: `exp = stim[2] ? stim[1] : stim[0]`. A bit of `mask` is set when its output differs from `exp`. In simulation, X/Z on an output counts as a mismatch (`!==`).
- FSM states:
  - IDLE: held while `enable` = 0. Counters and status are held. On `enable` = 1, go to SETTLE with `cnt` = 0; the current stimulus is treated as new.
  - SETTLE: `cnt` increments each clock. A change resets `cnt` to 0 and stays in SETTLE. When `cnt` = `SETTLE_CYCLES`-1 and there is no change, go to CHECK.
  - CHECK: one cycle. A change here aborts the check and goes to SETTLE with `cnt` = 0. Otherwise perform the check and go to HOLD. Performing the check means:
    - `vec_count`++;
    - if `mask` != 0, `err_count`++;
    - on the first failure, set `fail` and load `first_fail_vec` and `first_fail_mask`.
  - HOLD: wait. A change goes to SETTLE with `cnt` = 0.
  - Any state with `enable` = 0 goes to IDLE.
- Counters saturate at 2^`CNT_W`-1 and never wrap.
- `first_fail_*` are loaded only when `fail` goes 0→1. Later failures do not overwrite them.
- `clear` (highest priority among synchronous controls):
  - zeroes the counts, `fail`, and `first_fail_*`;
  - if enabled, restarts SETTLE with `cnt` = 0;
  - a check that coincides with `clear` is discarded.

## Timing
- Reset values: `check_strobe`=0, `vec_count`=0, `err_count`=0, `fail`=0, `pass`=0, `first_fail_vec`=0, `first_fail_mask`=0; FSM in IDLE; input registers 0.
- Let edge E0 be the edge that captures a changed stimulus into the input stage. With no further change, results update on edge E0+`SETTLE_CYCLES`+1. `check_strobe` is high for exactly the cycle following that edge, and all result outputs are valid in that cycle.
- `pass` is registered and changes on the same edge as the counters.
- A stimulus change on the same edge a check would occur: the change wins, there is no strobe, and the counts are unchanged.
- An asynchronous `rst_n` assertion at any point (for example mid-SETTLE or mid-CHECK) immediately forces all reset values. Operation restarts at the first `clk` edge after release.
- `enable` falling mid-SETTLE: no check and no strobe. The settle count restarts on re-enable.

## Test plan
- All three outputs correct, `SETTLE_CYCLES`=4, four vectors {sel,in1,in0} = 000, 001, 101, 110, each held 10 clocks → four strobes, each 5 clocks after the capture edge; `vec_count`=4, `err_count`=0, `pass`=1, `fail`=0.
- `mux_out_passgate` forced to 0 on vector 110, others correct → `err_count`=1, `fail`=1, `pass`=0, `first_fail_vec`=3'b110, `first_fail_mask`=3'b010.
- Stimulus toggling every 3 clocks with `SETTLE_CYCLES`=4 → no strobe, `vec_count`=0. Then held 10 clocks → exactly one strobe, `vec_count`=1.
- `CNT_W`=2, five vectors with `mux_out_rtl` inverted → `err_count`=3, `vec_count`=3 (saturated); `first_fail_*` hold the first vector; a second, different failure does not overwrite them.
- `clear` on the would-be check edge → no strobe, counts 0; the check recurs `SETTLE_CYCLES`+1 clocks later.
- Separately, `rst_n` pulsed low mid-HOLD with `fail`=1 → all outputs 0 immediately.

Source files
------------

// File: rtl/mux_response_checker.sv
// Response checker for the three 2:1 mux implementations: waits for the stimulus
// to settle, compares every output against sel ? in1 : in0 and accumulates results.
module mux_response_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             mux_in0,
  input  logic             mux_in1,
  input  logic             mux_sel,
  input  logic             mux_out_rtl,
  input  logic             mux_out_passgate,
  input  logic             mux_out_remodeled,
  output logic             check_strobe,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail,
  output logic             pass,
  output logic [2:0]       first_fail_vec,
  output logic [2:0]       first_fail_mask
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [7:0]       LAST_CNT = 8'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_reg, state_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic             fresh_reg, fresh_next;
  logic [2:0]       stim_reg, prev_reg, obs_reg;
  logic             change, change_eff, expected, do_check;
  logic [2:0]       mask;
  logic [CNT_W-1:0] vec_next, err_next;
  logic             fail_next;
  logic [2:0]       ffv_next, ffm_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_reg <= '0;
      prev_reg <= '0;
      obs_reg  <= '0;
    end else begin
      stim_reg <= {mux_sel, mux_in1, mux_in0};
      prev_reg <= stim_reg;
      obs_reg  <= {mux_out_remodeled, mux_out_passgate, mux_out_rtl};
    end
  end

  assign change   = (stim_reg != prev_reg);
  assign expected = stim_reg[2] ? stim_reg[1] : stim_reg[0];

  // A restart (enable rise or clear) behaves exactly like a freshly captured vector.
  assign change_eff = change | fresh_reg;

  // Case inequality so an X/Z output is reported as a mismatch in simulation.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_mask
      assign mask[gi] = (obs_reg[gi] !== expected);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      fresh_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      fresh_reg <= fresh_next;
    end
  end

  // The last settle cycle is also the check cycle, so results land S+1 edges after capture.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    fresh_next = 1'b0;
    do_check   = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else if (clear) begin
      state_next = SETTLE;
      cnt_next   = '0;
      fresh_next = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = SETTLE;
          cnt_next   = '0;
          fresh_next = 1'b1;
        end
        SETTLE: begin
          if (change_eff) begin
            cnt_next = '0;
          end else if (cnt_reg == LAST_CNT) begin
            do_check   = 1'b1;
            state_next = HOLD;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
        HOLD: begin
          if (change) begin
            state_next = SETTLE;
            cnt_next   = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    vec_next  = vec_count;
    err_next  = err_count;
    fail_next = fail;
    ffv_next  = first_fail_vec;
    ffm_next  = first_fail_mask;
    if (clear) begin
      vec_next  = '0;
      err_next  = '0;
      fail_next = 1'b0;
      ffv_next  = '0;
      ffm_next  = '0;
    end else if (do_check) begin
      if (vec_count != CNT_MAX) vec_next = vec_count + CNT_W'(1);
      if (|mask) begin
        if (err_count != CNT_MAX) err_next = err_count + CNT_W'(1);
        if (!fail) begin
          fail_next = 1'b1;
          ffv_next  = stim_reg;
          ffm_next  = mask;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_strobe    <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      fail            <= 1'b0;
      pass            <= 1'b0;
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
    end else begin
      check_strobe    <= do_check;
      vec_count       <= vec_next;
      err_count       <= err_next;
      fail            <= fail_next;
      pass            <= (vec_next != '0) && !fail_next;
      first_fail_vec  <= ffv_next;
      first_fail_mask <= ffm_next;
    end
  end

endmodule
